// File: rtl/rv32_issue_scoreboard.sv
// RV32 issue-stage scoreboard: tracks pending writes from long-latency ops
// and holds RAW/WAW hazards and serializing instructions until they resolve.
module rv32_issue_scoreboard (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dec_valid,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rs1_used,
  input  logic        i_rs2_used,
  input  logic        i_rd_write,
  input  logic        i_tracked,
  input  logic        i_serialize,
  input  logic        i_ex_ready,
  input  logic        i_flush,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  output logic        o_issue,
  output logic        o_stall,
  output logic [31:0] o_busy_vec,
  output logic [15:0] o_stall_cnt
);

  // state | meaning
  // RUN   | normal issue
  // DRAIN | serializing instr waiting for all tracked writes to retire
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] busy_q, busy_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] wb_mask, busy_eff;
  logic        raw, waw, ser;
  logic        issue, stall;

  // A writeback landing this cycle unblocks its consumers immediately.
  always_comb begin
    wb_mask = '0;
    if (i_wb_valid) wb_mask[i_wb_rd] = 1'b1;
    busy_eff = busy_q & ~wb_mask;
    raw = (i_rs1_used && (i_rs1_addr != 5'd0) && busy_eff[i_rs1_addr]) ||
          (i_rs2_used && (i_rs2_addr != 5'd0) && busy_eff[i_rs2_addr]);
    waw = i_rd_write && (i_rd_addr != 5'd0) && busy_eff[i_rd_addr];
    ser = i_serialize && (busy_eff != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (i_dec_valid && i_serialize && ser && !i_flush) state_d = DRAIN;
      DRAIN:   if ((busy_eff == '0) || i_flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    if (!i_rst) begin
      issue = i_dec_valid && i_ex_ready && !i_flush && !raw && !waw && !ser &&
              (state_q == RUN);
      stall = i_dec_valid && !i_flush && !issue;
    end
  end

  assign o_issue = issue;
  assign o_stall = stall;

  // Set applied after clear so a same-cycle reissue to the same rd wins.
  always_comb begin
    busy_d = busy_eff;
    if (issue && i_tracked && i_rd_write && (i_rd_addr != 5'd0))
      busy_d[i_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_busy_vec  = busy_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rv32_issue_scoreboard.sv
// Directed bench for rv32_issue_scoreboard: combinational hazard table plus
// hand-written multi-cycle sequences (load-use, WAW, collision, FENCE, reset, saturation).
module tb_rv32_issue_scoreboard;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_dec_valid;
  logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic        i_rs1_used, i_rs2_used, i_rd_write;
  logic        i_tracked, i_serialize, i_ex_ready, i_flush;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic        o_issue, o_stall;
  logic [31:0] o_busy_vec;
  logic [15:0] o_stall_cnt;

  int checks = 0;
  int errors = 0;

  rv32_issue_scoreboard dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dec_valid(i_dec_valid),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
    .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used), .i_rd_write(i_rd_write),
    .i_tracked(i_tracked), .i_serialize(i_serialize), .i_ex_ready(i_ex_ready),
    .i_flush(i_flush), .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
    .o_issue(o_issue), .o_stall(o_stall), .o_busy_vec(o_busy_vec),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       dv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ser;
    logic       rdy;
    logic       fl;
    logic       wbv;
    logic [4:0] wbrd;
    logic       exp_iss;
    logic       exp_stl;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_io(input string name, input logic exp_iss, input logic exp_stl);
    #2;
    chk({name, "_issue"}, {31'd0, o_issue}, {31'd0, exp_iss});
    chk({name, "_stall"}, {31'd0, o_stall}, {31'd0, exp_stl});
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_dec_valid = 1'b0; i_rs1_addr = 5'd0; i_rs2_addr = 5'd0; i_rd_addr = 5'd0;
    i_rs1_used = 1'b0; i_rs2_used = 1'b0; i_rd_write = 1'b0; i_tracked = 1'b0;
    i_serialize = 1'b0; i_ex_ready = 1'b0; i_flush = 1'b0;
    i_wb_valid = 1'b0; i_wb_rd = 5'd0;
  endtask

  task automatic tracked_issue(input logic [4:0] rd);
    idle_in();
    i_dec_valid = 1'b1; i_rd_addr = rd; i_rd_write = 1'b1;
    i_tracked = 1'b1; i_ex_ready = 1'b1;
  endtask

  task automatic fence_in();
    idle_in();
    i_dec_valid = 1'b1; i_serialize = 1'b1; i_ex_ready = 1'b1;
  endtask

  initial begin
    // Hazard table, evaluated with busy = {x5, x10}.
    //           dv    rs1    u1    rs2    u2    rd     wr    ser   rdy   fl    wbv   wbrd   iss   stl
    tbl[0]  = '{1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0};
    tbl[1]  = '{1'b1, 5'd5,  1'b1, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1};
    tbl[2]  = '{1'b1, 5'd5,  1'b0, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0};
    tbl[3]  = '{1'b1, 5'd1,  1'b1, 5'd10, 1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1};
    tbl[4]  = '{1'b1, 5'd1,  1'b1, 5'd10, 1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1};
    tbl[6]  = '{1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0};
    tbl[7]  = '{1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0};
    tbl[8]  = '{1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1};
    tbl[9]  = '{1'b1, 5'd5,  1'b1, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0};
    tbl[10] = '{1'b0, 5'd1,  1'b1, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0};
    tbl[11] = '{1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1};
    tbl[12] = '{1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1};
    tbl[13] = '{1'b1, 5'd5,  1'b1, 5'd2,  1'b0, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1};

    idle_in();
    i_rst = 1'b1;
    i_dec_valid = 1'b1; i_ex_ready = 1'b1;
    chk_io("reset", 1'b0, 1'b0);
    chk("reset_busy", o_busy_vec, 32'h0);
    chk("reset_cnt", {16'd0, o_stall_cnt}, 32'h0);
    cyc();
    i_rst = 1'b0;
    idle_in();

    tracked_issue(5'd5);
    chk_io("setup5", 1'b1, 1'b0);
    cyc();
    tracked_issue(5'd10);
    chk_io("setup10", 1'b1, 1'b0);
    cyc();
    idle_in();
    chk("setup_busy", o_busy_vec, 32'h0000_0420);

    for (int i = 0; i < 14; i++) begin
      cyc();
      i_dec_valid = tbl[i].dv; i_rs1_addr = tbl[i].rs1; i_rs1_used = tbl[i].u1;
      i_rs2_addr = tbl[i].rs2; i_rs2_used = tbl[i].u2; i_rd_addr = tbl[i].rd;
      i_rd_write = tbl[i].wr; i_tracked = 1'b0; i_serialize = tbl[i].ser;
      i_ex_ready = tbl[i].rdy; i_flush = tbl[i].fl;
      i_wb_valid = tbl[i].wbv; i_wb_rd = tbl[i].wbrd;
      chk_io($sformatf("vec%0d", i), tbl[i].exp_iss, tbl[i].exp_stl);
      #1 idle_in();
    end
    cyc();
    chk("table_busy_kept", o_busy_vec, 32'h0000_0420);
    chk("table_cnt", {16'd0, o_stall_cnt}, 32'h0);

    i_wb_valid = 1'b1; i_wb_rd = 5'd5;
    cyc();
    chk("wb5_busy", o_busy_vec, 32'h0000_0400);
    i_wb_rd = 5'd10;
    cyc();
    idle_in();
    chk("wb10_busy", o_busy_vec, 32'h0);

    // Load-use
    tracked_issue(5'd5);
    chk_io("lu_prod", 1'b1, 1'b0);
    cyc();
    chk("lu_busy_set", o_busy_vec, 32'h0000_0020);
    idle_in();
    i_dec_valid = 1'b1; i_rs1_addr = 5'd5; i_rs1_used = 1'b1;
    i_rd_addr = 5'd6; i_rd_write = 1'b1; i_ex_ready = 1'b1;
    chk_io("lu_stall1", 1'b0, 1'b1);
    cyc();
    chk_io("lu_stall2", 1'b0, 1'b1);
    cyc();
    i_wb_valid = 1'b1; i_wb_rd = 5'd5;
    chk_io("lu_wb_issue", 1'b1, 1'b0);
    cyc();
    idle_in();
    chk("lu_busy_clr", o_busy_vec, 32'h0);
    chk("lu_cnt", {16'd0, o_stall_cnt}, 32'd2);

    // WAW
    tracked_issue(5'd7);
    chk_io("waw_div", 1'b1, 1'b0);
    cyc();
    idle_in();
    i_dec_valid = 1'b1; i_rs1_addr = 5'd3; i_rs1_used = 1'b1;
    i_rd_addr = 5'd8; i_rd_write = 1'b1; i_ex_ready = 1'b1;
    chk_io("waw_unrelated", 1'b1, 1'b0);
    cyc();
    i_rd_addr = 5'd7;
    chk_io("waw_stall", 1'b0, 1'b1);
    cyc();
    i_wb_valid = 1'b1; i_wb_rd = 5'd7;
    chk_io("waw_wb_issue", 1'b1, 1'b0);
    cyc();
    idle_in();
    chk("waw_busy", o_busy_vec, 32'h0);
    chk("waw_cnt", {16'd0, o_stall_cnt}, 32'd3);

    // Set/clear collision on x9
    tracked_issue(5'd9);
    cyc();
    tracked_issue(5'd9);
    i_wb_valid = 1'b1; i_wb_rd = 5'd9;
    chk_io("coll", 1'b1, 1'b0);
    cyc();
    idle_in();
    chk("coll_busy", o_busy_vec, 32'h0000_0200);
    i_wb_valid = 1'b1; i_wb_rd = 5'd9;
    cyc();
    idle_in();
    chk("coll_clr", o_busy_vec, 32'h0);

    // x0 never tracked
    tracked_issue(5'd0);
    chk_io("x0_issue", 1'b1, 1'b0);
    cyc();
    idle_in();
    chk("x0_busy", o_busy_vec, 32'h0);

    // FENCE drain with x4 and x6 outstanding
    tracked_issue(5'd4);
    cyc();
    tracked_issue(5'd6);
    cyc();
    chk("fence_setup", o_busy_vec, 32'h0000_0050);
    fence_in();
    chk_io("fence_run", 1'b0, 1'b1);
    cyc();
    i_wb_valid = 1'b1; i_wb_rd = 5'd4;
    chk_io("fence_drain_wb4", 1'b0, 1'b1);
    cyc();
    i_wb_valid = 1'b0;
    chk("fence_busy6", o_busy_vec, 32'h0000_0040);
    chk_io("fence_drain", 1'b0, 1'b1);
    cyc();
    i_wb_valid = 1'b1; i_wb_rd = 5'd6;
    chk_io("fence_drain_wb6", 1'b0, 1'b1);
    cyc();
    i_wb_valid = 1'b0;
    chk("fence_busy0", o_busy_vec, 32'h0);
    chk_io("fence_issue", 1'b1, 1'b0);
    cyc();
    idle_in();
    chk("fence_cnt", {16'd0, o_stall_cnt}, 32'd7);

    // Async reset in DRAIN
    tracked_issue(5'd4);
    cyc();
    fence_in();
    cyc();
    chk("rst_setup", o_busy_vec, 32'h0000_0010);
    chk_io("rst_draining", 1'b0, 1'b1);
    i_rst = 1'b1;
    #1;
    chk("rst_busy", o_busy_vec, 32'h0);
    chk("rst_cnt", {16'd0, o_stall_cnt}, 32'h0);
    chk_io("rst_out", 1'b0, 1'b0);
    i_rst = 1'b0;
    chk_io("rst_run", 1'b1, 1'b0);
    cyc();
    idle_in();

    // Stall counter saturation
    i_dec_valid = 1'b1; i_ex_ready = 1'b0;
    repeat (65534) cyc();
    chk("sat_fffe", {16'd0, o_stall_cnt}, 32'h0000_FFFE);
    cyc();
    chk("sat_ffff", {16'd0, o_stall_cnt}, 32'h0000_FFFF);
    repeat (5) cyc();
    chk("sat_hold", {16'd0, o_stall_cnt}, 32'h0000_FFFF);
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
